fetch_sequencer: RTL and testbench

Instruction-fetch sequencer for the core. Owns the program counter, issues instruction-memory requests over a req/ack handshake, and presents fetched instructions to decode with a valid/stall interface. Redirects come from the execute-stage PC-select encoding. Any redirect kills younger work, and the response to an in-flight request is drained safely before fetch resumes. A one-entry skid buffer absorbs a response that arrives while decode is stalled.

---
 rtl/core_pkg.sv | 18 +
 rtl/fetch_sequencer_if.sv | 25 ++
 rtl/fetch_skid_reg.sv | 35 +++
 rtl/fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: PC-select encodings, fetch FSM states and default widths.
package core_pkg;

  localparam int DEFAULT_PC_W = 16;
  localparam int INSTR_W      = 16;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetch_state_e;

  // 2'b11 is deliberately not a redirect; it behaves as sequential.
  function automatic logic is_redirect(logic [1:0] pcsrc);
    return (pcsrc == PCSRC_BR) || (pcsrc == PCSRC_JR);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch bus bundle: instruction-memory req/ack port plus the decode valid/stall port.
interface fetch_sequencer_if
  import core_pkg::*;
#(
  parameter int PC_W = DEFAULT_PC_W
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall_in;
  logic               if_valid;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_ack, imem_rdata, stall_in
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_ack, imem_rdata, stall_in
  );
endinterface

// File: rtl/fetch_skid_reg.sv
// One-entry {pc,instr} skid buffer; clear beats load, load beats unload.
module fetch_skid_reg
  import core_pkg::*;
#(
  parameter int PC_W = DEFAULT_PC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               unload,
  input  logic               clear,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               full
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full      <= 1'b1;
      out_pc    <= in_pc;
      out_instr <= in_instr;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: PC owner, imem req/ack master, decode valid/stall source.
// Optional FETCH_STATS_EN adds saturating stat_fetched / stat_redirects counters.
module fetch_sequencer
  import core_pkg::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pcsrc,
  input  logic [PC_W-1:0] br_target,
  input  logic [PC_W-1:0] jr_target,
  output logic            flush,
`ifdef FETCH_STATS_EN
  output logic [15:0]     stat_fetched,
  output logic [15:0]     stat_redirects,
`endif
  fetch_sequencer_if.master bus
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  fetch_state_e       state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    drain_addr;
  logic [PC_W-1:0]    target;
  logic               redirect;
  logic               req_q;
  logic               valid_q;
  logic [PC_W-1:0]    if_pc_q;
  logic [INSTR_W-1:0] if_instr_q;
  logic               skid_load;
  logic               skid_unload;
  logic               skid_full;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;

  assign pc_inc   = pc + PC_ONE;
  assign redirect = is_redirect(pcsrc);
  assign flush    = redirect;

  always_comb begin
    target = pc_inc;
    case (pcsrc)
      PCSRC_BR:  target = br_target;
      PCSRC_JR:  target = jr_target;
      PCSRC_SEQ: target = pc_inc;
      default:   target = pc_inc;
    endcase
  end

  assign skid_load   = (state == REQ) && !redirect && bus.imem_ack && valid_q && bus.stall_in;
  assign skid_unload = (state == HOLD) && !redirect && !bus.stall_in;

  fetch_skid_reg #(.PC_W(PC_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (skid_unload),
    .clear     (redirect),
    .in_pc     (pc),
    .in_instr  (bus.imem_rdata),
    .out_pc    (skid_pc),
    .out_instr (skid_instr),
    .full      (skid_full)
  );

  // A stale request keeps its original address on the bus until its ack drains it.
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = (state == DRAIN) ? drain_addr : pc;
  assign bus.if_valid  = valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_addr <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else if (redirect) begin
      pc      <= target;
      valid_q <= 1'b0;
      req_q   <= 1'b1;
      case (state)
        REQ: begin
          if (!bus.imem_ack) begin
            drain_addr <= pc;
            state      <= DRAIN;
          end
        end
        // An ack landing with the newer redirect already drains the stale request.
        DRAIN: begin
          if (bus.imem_ack) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          req_q <= 1'b1;
        end
        REQ: begin
          if (bus.imem_ack) begin
            pc <= pc_inc;
            if (!valid_q || !bus.stall_in) begin
              if_pc_q    <= pc;
              if_instr_q <= bus.imem_rdata;
              valid_q    <= 1'b1;
            end else begin
              state <= HOLD;
              req_q <= 1'b0;
            end
          end else if (valid_q && !bus.stall_in) begin
            valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!bus.stall_in) begin
            if_pc_q    <= skid_pc;
            if_instr_q <= skid_instr;
            valid_q    <= skid_full;
            state      <= REQ;
            req_q      <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.imem_ack) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic consume;
  assign consume = valid_q && !bus.stall_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched   <= '0;
      stat_redirects <= '0;
    end else begin
      if (consume && (stat_fetched != 16'hFFFF)) stat_fetched <= stat_fetched + 16'd1;
      if (flush && (stat_redirects != 16'hFFFF)) stat_redirects <= stat_redirects + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: per-cycle vector tables fed through a scoreboard queue,
// plus hand sequences for PC wrap and (with FETCH_STATS_EN) the statistics counters.
module tb_fetch_sequencer;
  import core_pkg::*;

  typedef struct {
    int          idx;
    logic        rst;
    logic [1:0]  pcsrc;
    logic [15:0] br;
    logic [15:0] jr;
    logic        stall;
    int          lat;
    logic        chk;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic        flush;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pcsrc = 2'b00;
  logic [15:0] br_target = 16'h0;
  logic [15:0] jr_target = 16'h0;
  logic        flush;
  logic        wflush;
  int          lat = 1;
  int          mcnt = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  int          row_id = 0;
  int          exp_fetched = 0;
  int          exp_redirects = 0;
  vec_t        vecs[$];
  vec_t        exp_q[$];

`ifdef FETCH_STATS_EN
  logic [15:0] stat_fetched, stat_redirects;
  logic [15:0] wstat_fetched, wstat_redirects;
`endif

  fetch_sequencer_if #(.PC_W(16)) bus ();
  fetch_sequencer_if #(.PC_W(16)) wbus ();

  always #5 clk = ~clk;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  // Memory with 'lat' cycles of latency; lat=1 acks in the same cycle as the request.
  assign bus.imem_ack   = bus.imem_req && (mcnt == lat - 1);
  assign bus.imem_rdata = memWord(bus.imem_addr);

  always @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ack) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  assign wbus.imem_ack   = wbus.imem_req;
  assign wbus.imem_rdata = memWord(wbus.imem_addr);
  assign wbus.stall_in   = 1'b0;

  fetch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .pcsrc          (pcsrc),
    .br_target      (br_target),
    .jr_target      (jr_target),
    .flush          (flush),
`ifdef FETCH_STATS_EN
    .stat_fetched   (stat_fetched),
    .stat_redirects (stat_redirects),
`endif
    .bus            (bus)
  );

  fetch_sequencer #(.PC_W(16), .RESET_PC(16'hFFFE)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .pcsrc          (2'b00),
    .br_target      (16'h0000),
    .jr_target      (16'h0000),
    .flush          (wflush),
`ifdef FETCH_STATS_EN
    .stat_fetched   (wstat_fetched),
    .stat_redirects (wstat_redirects),
`endif
    .bus            (wbus)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // The unselected target gets a decoy value so a swapped mux is visible.
  task automatic add(input logic [1:0] ps, input logic [15:0] tgt, input logic st, input int lt,
                     input logic rq, input logic [15:0] ad, input logic vl,
                     input logic [15:0] pcv, input logic fl);
    vec_t v;
    v.idx   = row_id;
    row_id++;
    v.rst   = 1'b0;
    v.pcsrc = ps;
    v.br    = (ps == PCSRC_JR) ? (tgt ^ 16'h0F0F) : tgt;
    v.jr    = (ps == PCSRC_JR) ? tgt : (tgt ^ 16'h0F0F);
    v.stall = st;
    v.lat   = lt;
    v.chk   = 1'b1;
    v.req   = rq;
    v.addr  = ad;
    v.valid = vl;
    v.pc    = pcv;
    v.flush = fl;
    vecs.push_back(v);
  endtask

  task automatic addReset(input int lt, input logic ck);
    vec_t v;
    v.idx   = row_id;
    row_id++;
    v.rst   = 1'b1;
    v.pcsrc = PCSRC_SEQ;
    v.br    = 16'h0;
    v.jr    = 16'h0;
    v.stall = 1'b0;
    v.lat   = lt;
    v.chk   = ck;
    v.req   = 1'b0;
    v.addr  = 16'h0;
    v.valid = 1'b0;
    v.pc    = 16'h0;
    v.flush = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst;
    pcsrc        = v.pcsrc;
    br_target    = v.br;
    jr_target    = v.jr;
    bus.stall_in = v.stall;
    lat          = v.lat;
    exp_q.push_back(v);
  endtask

  task automatic checkOutput();
    vec_t  v;
    string t;
    v = exp_q.pop_front();
    t = $sformatf("row%0d", v.idx);
    if (v.rst) begin
      exp_fetched   = 0;
      exp_redirects = 0;
    end
    if (v.chk) begin
      cmp({t, " imem_req"}, 32'(bus.imem_req), 32'(v.req));
      if (v.req) cmp({t, " imem_addr"}, 32'(bus.imem_addr), 32'(v.addr));
      cmp({t, " if_valid"}, 32'(bus.if_valid), 32'(v.valid));
      if (v.valid || v.rst) begin
        cmp({t, " if_pc"}, 32'(bus.if_pc), 32'(v.pc));
        cmp({t, " if_instr"}, 32'(bus.if_instr), v.rst ? 32'h0 : 32'(memWord(v.pc)));
      end
      cmp({t, " flush"}, 32'(flush), 32'(v.flush));
    end
    if (!v.rst) begin
      if (v.valid && !v.stall) exp_fetched++;
      if (v.flush) exp_redirects++;
    end
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput();
    end
  endtask

`ifdef FETCH_STATS_EN
  task automatic checkStats(input string tag);
    @(posedge clk);
    @(negedge clk);
    cmp({tag, " stat_fetched"}, 32'(stat_fetched),
        (exp_fetched > 65535) ? 32'hFFFF : 32'(exp_fetched));
    cmp({tag, " stat_redirects"}, 32'(stat_redirects),
        (exp_redirects > 65535) ? 32'hFFFF : 32'(exp_redirects));
  endtask
`endif

  // Zero-wait fetch, a 3-cycle stall that parks pc=3 in the skid, then redirects in REQ and HOLD.
  task automatic buildZeroWait();
    vecs.delete();
    addReset(1, 1'b0);
    addReset(1, 1'b1);
    add(PCSRC_SEQ, 16'h00, 0, 1, 0, 16'h00, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h00, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h01, 1, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h02, 1, 16'h01, 0);
    add(PCSRC_SEQ, 16'h00, 1, 1, 1, 16'h03, 1, 16'h02, 0);
    add(PCSRC_SEQ, 16'h00, 1, 1, 0, 16'h00, 1, 16'h02, 0);
    add(PCSRC_SEQ, 16'h00, 1, 1, 0, 16'h00, 1, 16'h02, 0);
    add(PCSRC_SEQ, 16'h00, 0, 1, 0, 16'h00, 1, 16'h02, 0);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h04, 1, 16'h03, 0);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h05, 1, 16'h04, 0);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h06, 1, 16'h05, 0);
    add(PCSRC_BR,  16'h30, 0, 1, 1, 16'h07, 1, 16'h06, 1);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h30, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h31, 1, 16'h30, 0);
    add(2'b11,     16'h77, 0, 1, 1, 16'h32, 1, 16'h31, 0);
    add(2'b11,     16'h77, 0, 1, 1, 16'h33, 1, 16'h32, 0);
    add(PCSRC_JR,  16'h50, 0, 1, 1, 16'h34, 1, 16'h33, 1);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h50, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h51, 1, 16'h50, 0);
    add(PCSRC_SEQ, 16'h00, 1, 1, 1, 16'h52, 1, 16'h51, 0);
    add(PCSRC_JR,  16'h60, 1, 1, 0, 16'h00, 1, 16'h51, 1);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h60, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 1, 1, 16'h61, 1, 16'h60, 0);
  endtask

  // 3-cycle memory: redirect to 0x40 while 5 is outstanding, then two redirects around a drain.
  task automatic buildSlowMem();
    vecs.delete();
    addReset(3, 1'b0);
    addReset(3, 1'b1);
    add(PCSRC_SEQ, 16'h00, 0, 3, 0, 16'h00, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h00, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h00, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h00, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h01, 1, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h01, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h01, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h02, 1, 16'h01, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h02, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h02, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h03, 1, 16'h02, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h03, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h03, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h04, 1, 16'h03, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h04, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h04, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h05, 1, 16'h04, 0);
    add(PCSRC_BR,  16'h40, 0, 3, 1, 16'h05, 0, 16'h00, 1);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h05, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h40, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h40, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h40, 0, 16'h00, 0);
    add(PCSRC_JR,  16'h10, 0, 3, 1, 16'h41, 1, 16'h40, 1);
    add(PCSRC_BR,  16'h20, 0, 3, 1, 16'h41, 0, 16'h00, 1);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h41, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h20, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h20, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h20, 0, 16'h00, 0);
    add(PCSRC_SEQ, 16'h00, 0, 3, 1, 16'h21, 1, 16'h20, 0);
  endtask

  task automatic wrapSequence();
    logic [15:0] exp_a [3];
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000};
    @(posedge clk);
    #1;
    rst          = 1'b1;
    pcsrc        = PCSRC_SEQ;
    bus.stall_in = 1'b0;
    lat          = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c <= 3) begin
        cmp($sformatf("wrap c%0d imem_req", c), 32'(wbus.imem_req), 32'h1);
        cmp($sformatf("wrap c%0d imem_addr", c), 32'(wbus.imem_addr), 32'(exp_a[c-1]));
      end
      if (c >= 2) begin
        cmp($sformatf("wrap c%0d if_valid", c), 32'(wbus.if_valid), 32'h1);
        cmp($sformatf("wrap c%0d if_pc", c), 32'(wbus.if_pc), 32'(exp_a[c-2]));
      end
    end
  endtask

  initial begin
    bus.stall_in = 1'b0;
    $display("[TB] zero-wait fetch, stall into skid, redirects");
    buildZeroWait();
    runTable();
`ifdef FETCH_STATS_EN
    checkStats("zero-wait");
`endif
    $display("[TB] slow memory, drain and latest-wins redirect");
    buildSlowMem();
    runTable();
`ifdef FETCH_STATS_EN
    checkStats("slow-mem");
`endif
    $display("[TB] PC wrap from 0xFFFE");
    wrapSequence();
`ifdef FETCH_STATS_EN
    $display("[TB] stat_fetched saturation");
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    cmp("sat stat_fetched", 32'(stat_fetched), 32'hFFFF);
    cmp("sat stat_redirects", 32'(stat_redirects), 32'h0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
